pc_source_ctrl: RTL and testbench
=================================

Name: pc_source_ctrl

Overview:
- Next-generation PC source controller for the AVR-style core.
- Decodes the opcode field of the instruction register and selects among four PC sources: sequential, jump target, branch target and return address.
- Owns a parametrised hardware return-address stack (RAS) and sequences pipeline flush bubbles after every taken redirect.
- Sits between the instruction register and the PC mux/PC register. Its outputs are stable before the PC register's rising-edge load.

Parameters:
- OPC_W, 6, width of opcode field.
- PC_W, 16, program counter width.
- RAS_DEPTH, 4, return-stack entries (≥2).
- FLUSH_CYCLES, 2, falling edges with flush asserted per taken redirect (≥1).
- OPC_JMP, 6'b110000, unconditional jump opcode.
- OPC_BRZ, 6'b110001, branch-if-zero opcode.
- OPC_CALL, 6'b110010, call opcode.
- OPC_RET, 6'b110011, return opcode.

Ports:
- clk  in  1  core clock; all state updates on the falling edge.
- rst  in  1  synchronous, active-high reset, sampled on the falling edge of clk.
- ireg_in  in  OPC_W  opcode field of the current instruction.
- ir_valid  in  1  ireg_in holds a valid instruction.
- zero_flag  in  1  ALU Z flag.
- pc_in  in  PC_W  current PC value.
- pc_sel  out  2  0=PC+1, 1=jump target, 2=branch target, 3=ras_out.
- pc_load  out  1  PC register loads on the next rising edge.
- flush  out  1  kill the fetched/decoded instruction.
- ras_out  out  PC_W  return address for pc_sel=3.
- stack_err  out  1  sticky RAS overflow/underflow.
- redirect_cnt  out  16  taken-redirect count (see Optional Feature).

Behaviour:
- All outputs are registered and update on the falling edge of clk.
- Reset values: pc_sel=0, pc_load=1, flush=0, ras_out=0, stack_err=0, redirect_cnt=0. The RAS is emptied (sp=0) and the FSM enters RUN.
- Reset wins over any simultaneous event.
- FSM states: RUN and FLUSH.
- RUN with ir_valid=0: pc_sel=0, pc_load=0 (stall/hold), flush=0.
- RUN with ir_valid=1:
  - JMP: pc_sel=1, taken.
  - BRZ: if zero_flag=1, pc_sel=2, taken; else pc_sel=0, not taken.
  - CALL: push pc_in+1 (modulo 2^PC_W) onto the RAS; pc_sel=1, taken.
  - CALL with RAS full (sp=RAS_DEPTH): push dropped, stack_err set, jump still taken.
  - RET with RAS non-empty: pop; ras_out = popped entry on the same edge; pc_sel=3, taken.
  - RET with RAS empty: stack_err set, pc_sel=0, not taken, no flush.
  - Any other opcode: pc_sel=0.
  - In all ir_valid=1 cases, pc_load=1.
- Taken redirect edge: flush=1, pc_load=1. If FLUSH_CYCLES>1, go to FLUSH with cnt=FLUSH_CYCLES-1; otherwise stay in RUN.
- FLUSH:
  - ireg_in and ir_valid are ignored.
  - pc_sel=0, pc_load=1, flush=1.
  - cnt decrements each edge; when cnt reaches 1 on entry to the edge, return to RUN on that edge.
  - Result: total flush length is FLUSH_CYCLES edges including the redirect edge.
- Not-taken instructions produce flush=0.
- RAS:
  - LIFO, sp ranges 0..RAS_DEPTH.
  - No wrap-around; entries are not cleared on pop.
  - ras_out holds its last value when not popping.
- stack_err clears only on rst.
- Opcode decode is an exact match on all OPC_W bits.

Optional Feature:
- Macro: PC_SRC_PERF_EN.
- Defined:
  - redirect_cnt increments by 1 on every taken redirect edge (JMP, taken BRZ, CALL, successful RET).
  - Saturates at 16'hFFFF.
  - Cleared by rst.
- Undefined: redirect_cnt is tied to 0 and no counter logic is synthesised.

Test Plan:
- Reset: hold rst for 2 edges with ireg_in=OPC_JMP, ir_valid=1 → pc_sel=0, flush=0, pc_load=1, stack_err=0.
- JMP with FLUSH_CYCLES=2: ireg_in=6'b110000, ir_valid=1 → pc_sel=1 and flush=1 on edge N. On edge N+1: pc_sel=0, flush=1, with OPC_JMP still presented and ignored. On edge N+2: flush=0.
- BRZ: BRZ with zero_flag=0 → pc_sel=0, flush=0. BRZ with zero_flag=1 → pc_sel=2, flush=1.
- CALL/RET nesting: CALL at pc_in=16'h0010, then CALL at 16'h0020, then RET, RET → ras_out=16'h0021 then 16'h0011, with pc_sel=3 on each RET.
- RAS overflow/underflow, RAS_DEPTH=4: 5 CALLs → stack_err=1 after the 5th, and 4 RETs return the first four addresses. A further RET → pc_sel=0, flush=0.
- Stall and reset mid-flush: ir_valid=0 → pc_load=0. rst asserted during FLUSH → RUN, flush=0 on the next edge. With PC_SRC_PERF_EN defined, 3 taken redirects → redirect_cnt=3.

Source files
------------

// File: rtl/pc_source_ctrl.sv
// ---------------------------------------------------------------------------
// pc_source_ctrl
//
// PC source controller for the AVR-style core. Decodes the opcode field of
// the instruction register and selects the next PC source (sequential, jump
// target, branch target or return address). Owns a small hardware
// return-address stack and sequences flush bubbles after every taken redirect.
// All state and outputs update on the falling edge of clk so they are stable
// before the PC register loads on the following rising edge.
//
// Ports:
//   clk          core clock (falling-edge state updates)
//   rst          synchronous active-high reset, sampled on the falling edge
//   ireg_in      opcode field of the current instruction
//   ir_valid     ireg_in holds a valid instruction
//   zero_flag    ALU Z flag
//   pc_in        current PC value
//   pc_sel       0=PC+1, 1=jump target, 2=branch target, 3=ras_out
//   pc_load      PC register loads on the next rising edge
//   flush        kill the fetched/decoded instruction
//   ras_out      return address used when pc_sel=3
//   stack_err    sticky RAS overflow/underflow flag
//   redirect_cnt taken-redirect counter
//
// Optional feature macro: PC_SRC_PERF_EN
//   defined   : redirect_cnt counts taken redirects, saturating at 16'hFFFF
//   undefined : redirect_cnt is tied to zero, no counter logic
// ---------------------------------------------------------------------------
module pc_source_ctrl #(
   parameter int unsigned     OPC_W        = 6,
   parameter int unsigned     PC_W         = 16,
   parameter int unsigned     RAS_DEPTH    = 4,
   parameter int unsigned     FLUSH_CYCLES = 2,
   parameter logic [OPC_W-1:0] OPC_JMP     = 6'b110000,
   parameter logic [OPC_W-1:0] OPC_BRZ     = 6'b110001,
   parameter logic [OPC_W-1:0] OPC_CALL    = 6'b110010,
   parameter logic [OPC_W-1:0] OPC_RET     = 6'b110011
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [OPC_W-1:0] ireg_in,
   input  logic             ir_valid,
   input  logic             zero_flag,
   input  logic [PC_W-1:0]  pc_in,
   output logic [1:0]       pc_sel,
   output logic             pc_load,
   output logic             flush,
   output logic [PC_W-1:0]  ras_out,
   output logic             stack_err,
   output logic [15:0]      redirect_cnt
);

   localparam int unsigned SP_W  = $clog2(RAS_DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(RAS_DEPTH);
   localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   localparam logic [SP_W-1:0]  SP_FULL   = SP_W'(RAS_DEPTH);
   localparam logic [CNT_W-1:0] CNT_START = CNT_W'(FLUSH_CYCLES - 1);

   localparam logic [1:0] SEL_SEQ  = 2'd0;
   localparam logic [1:0] SEL_JMP  = 2'd1;
   localparam logic [1:0] SEL_BRZ  = 2'd2;
   localparam logic [1:0] SEL_RET  = 2'd3;

   typedef enum logic [0:0] {StRun, StFlush} state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SP_W-1:0]   sp_q, sp_d;
   logic [PC_W-1:0]   ras_q [RAS_DEPTH];

   logic [1:0]        pc_sel_q, pc_sel_d;
   logic              pc_load_q, pc_load_d;
   logic              flush_q, flush_d;
   logic [PC_W-1:0]   ras_out_q, ras_out_d;
   logic              stack_err_q, stack_err_d;

   logic              taken;
   logic              push_en;
   logic [SP_W-1:0]   sp_m1;
   logic [PC_W-1:0]   ret_addr;

   assign sp_m1    = sp_q - SP_W'(1);
   assign ret_addr = pc_in + PC_W'(1);

   // -------------------------------------------------------------------------
   // Next-state and registered-output decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sp_d        = sp_q;
      pc_sel_d    = SEL_SEQ;
      pc_load_d   = 1'b1;
      flush_d     = 1'b0;
      ras_out_d   = ras_out_q;
      stack_err_d = stack_err_q;
      taken       = 1'b0;
      push_en     = 1'b0;

      unique case (state_q)
         StRun: begin
            if (!ir_valid) begin
               // Stall: hold the PC.
               pc_load_d = 1'b0;
            end else begin
               case (ireg_in)
                  OPC_JMP: begin
                     pc_sel_d = SEL_JMP;
                     taken    = 1'b1;
                  end
                  OPC_BRZ: begin
                     if (zero_flag) begin
                        pc_sel_d = SEL_BRZ;
                        taken    = 1'b1;
                     end
                  end
                  OPC_CALL: begin
                     // A full stack drops the push but the jump still happens.
                     if (sp_q == SP_FULL) begin
                        stack_err_d = 1'b1;
                     end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                     end
                     pc_sel_d = SEL_JMP;
                     taken    = 1'b1;
                  end
                  OPC_RET: begin
                     if (sp_q == '0) begin
                        stack_err_d = 1'b1;
                     end else begin
                        sp_d      = sp_m1;
                        ras_out_d = ras_q[sp_m1[IDX_W-1:0]];
                        pc_sel_d  = SEL_RET;
                        taken     = 1'b1;
                     end
                  end
                  default: pc_sel_d = SEL_SEQ;
               endcase
            end

            if (taken) begin
               flush_d = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  state_d = StFlush;
                  cnt_d   = CNT_START;
               end
            end
         end

         StFlush: begin
            // Instruction inputs are ignored while bubbles drain.
            flush_d = 1'b1;
            if (cnt_q <= CNT_W'(1)) begin
               state_d = StRun;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end

         default: state_d = StRun;
      endcase
   end

   // -------------------------------------------------------------------------
   // State and output registers (falling edge, synchronous reset)
   // -------------------------------------------------------------------------
   always_ff @(negedge clk) begin
      if (rst) begin
         state_q     <= StRun;
         cnt_q       <= '0;
         sp_q        <= '0;
         pc_sel_q    <= SEL_SEQ;
         pc_load_q   <= 1'b1;
         flush_q     <= 1'b0;
         ras_out_q   <= '0;
         stack_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sp_q        <= sp_d;
         pc_sel_q    <= pc_sel_d;
         pc_load_q   <= pc_load_d;
         flush_q     <= flush_d;
         ras_out_q   <= ras_out_d;
         stack_err_q <= stack_err_d;
      end
   end

   // Stack storage has no reset; entries are not cleared on pop.
   always_ff @(negedge clk) begin
      if (!rst && push_en) begin
         ras_q[sp_q[IDX_W-1:0]] <= ret_addr;
      end
   end

   assign pc_sel    = pc_sel_q;
   assign pc_load   = pc_load_q;
   assign flush     = flush_q;
   assign ras_out   = ras_out_q;
   assign stack_err = stack_err_q;

`ifdef PC_SRC_PERF_EN
   logic [15:0] redirect_cnt_q;

   always_ff @(negedge clk) begin
      if (rst) begin
         redirect_cnt_q <= '0;
      end else if (taken && (redirect_cnt_q != 16'hFFFF)) begin
         redirect_cnt_q <= redirect_cnt_q + 16'd1;
      end
   end

   assign redirect_cnt = redirect_cnt_q;
`else
   assign redirect_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pc_source_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_source_ctrl
//
// Self-checking bench for pc_source_ctrl with default parameters. Inputs are
// driven on the rising edge, the DUT updates on the falling edge, and outputs
// are compared on the following rising edge.
// ---------------------------------------------------------------------------
module tb_pc_source_ctrl;

   localparam logic [5:0] JMP  = 6'b110000;
   localparam logic [5:0] BRZ  = 6'b110001;
   localparam logic [5:0] CALL = 6'b110010;
   localparam logic [5:0] RET  = 6'b110011;
   localparam logic [5:0] NOP  = 6'b000000;
   localparam logic [5:0] NEAR = 6'b110100;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  ireg_in;
   logic        ir_valid;
   logic        zero_flag;
   logic [15:0] pc_in;
   logic [1:0]  pc_sel;
   logic        pc_load;
   logic        flush;
   logic [15:0] ras_out;
   logic        stack_err;
   logic [15:0] redirect_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_source_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .ireg_in      (ireg_in),
      .ir_valid     (ir_valid),
      .zero_flag    (zero_flag),
      .pc_in        (pc_in),
      .pc_sel       (pc_sel),
      .pc_load      (pc_load),
      .flush        (flush),
      .ras_out      (ras_out),
      .stack_err    (stack_err),
      .redirect_cnt (redirect_cnt)
   );

   typedef struct {
      logic        r;
      logic [5:0]  op;
      logic        v;
      logic        z;
      logic [15:0] pc;
      logic [1:0]  sel;
      logic        load;
      logic        fl;
      logic [15:0] ras;
      logic        err;
   } vec_t;

   vec_t vecs [20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one instruction, let the DUT take its falling edge, sample on rise.
   task automatic step(input logic r, input logic [5:0] op, input logic v,
                       input logic z, input logic [15:0] pc);
      rst       = r;
      ireg_in   = op;
      ir_valid  = v;
      zero_flag = z;
      pc_in     = pc;
      @(negedge clk);
      @(posedge clk);
   endtask

   task automatic chk_out(input string name, input logic [1:0] sel, input logic load,
                          input logic fl);
      chk({name, ".pc_sel"}, 32'(pc_sel), 32'(sel));
      chk({name, ".pc_load"}, 32'(pc_load), 32'(load));
      chk({name, ".flush"}, 32'(flush), 32'(fl));
   endtask

   initial begin
      //          r  op    v  z  pc        sel load fl ras      err
      vecs[0]  = '{1, JMP,  1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0};
      vecs[1]  = '{1, JMP,  1, 0, 16'h0000, 0, 1, 0, 16'h0000, 0};
      vecs[2]  = '{0, NOP,  0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0};
      vecs[3]  = '{0, JMP,  1, 0, 16'h0005, 1, 1, 1, 16'h0000, 0};
      vecs[4]  = '{0, JMP,  1, 0, 16'h0006, 0, 1, 1, 16'h0000, 0};
      vecs[5]  = '{0, NOP,  1, 0, 16'h0007, 0, 1, 0, 16'h0000, 0};
      vecs[6]  = '{0, BRZ,  1, 0, 16'h0008, 0, 1, 0, 16'h0000, 0};
      vecs[7]  = '{0, BRZ,  1, 1, 16'h0009, 2, 1, 1, 16'h0000, 0};
      vecs[8]  = '{0, NOP,  1, 0, 16'h000A, 0, 1, 1, 16'h0000, 0};
      vecs[9]  = '{0, CALL, 1, 0, 16'h0010, 1, 1, 1, 16'h0000, 0};
      vecs[10] = '{0, NOP,  1, 0, 16'h0011, 0, 1, 1, 16'h0000, 0};
      vecs[11] = '{0, CALL, 1, 0, 16'h0020, 1, 1, 1, 16'h0000, 0};
      vecs[12] = '{0, NOP,  1, 0, 16'h0021, 0, 1, 1, 16'h0000, 0};
      vecs[13] = '{0, RET,  1, 0, 16'h0030, 3, 1, 1, 16'h0021, 0};
      vecs[14] = '{0, NOP,  1, 0, 16'h0031, 0, 1, 1, 16'h0021, 0};
      vecs[15] = '{0, RET,  1, 0, 16'h0022, 3, 1, 1, 16'h0011, 0};
      vecs[16] = '{0, NOP,  1, 0, 16'h0023, 0, 1, 1, 16'h0011, 0};
      vecs[17] = '{0, RET,  1, 0, 16'h0012, 0, 1, 0, 16'h0011, 1};
      vecs[18] = '{0, NOP,  0, 0, 16'h0013, 0, 0, 0, 16'h0011, 1};
      vecs[19] = '{0, NEAR, 1, 1, 16'h0013, 0, 1, 0, 16'h0011, 1};

      rst = 1'b1; ireg_in = NOP; ir_valid = 1'b0; zero_flag = 1'b0; pc_in = '0;
      @(posedge clk);

      for (int i = 0; i < 20; i++) begin
         step(vecs[i].r, vecs[i].op, vecs[i].v, vecs[i].z, vecs[i].pc);
         chk_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].load, vecs[i].fl);
         chk($sformatf("vec%0d.ras_out", i), 32'(ras_out), 32'(vecs[i].ras));
         chk($sformatf("vec%0d.stack_err", i), 32'(stack_err), 32'(vecs[i].err));
      end

      // RAS overflow: five calls, fifth push dropped.
      step(1, NOP, 0, 0, 16'h0000);
      chk("ovf.reset_err", 32'(stack_err), 32'd0);
      for (int i = 0; i < 5; i++) begin
         step(0, CALL, 1, 0, 16'h0100 + 16'(i));
         chk($sformatf("ovf.call%0d.sel", i), 32'(pc_sel), 32'd1);
         chk($sformatf("ovf.call%0d.err", i), 32'(stack_err), (i == 4) ? 32'd1 : 32'd0);
         step(0, NOP, 1, 0, 16'h0000);
      end
      for (int i = 0; i < 4; i++) begin
         step(0, RET, 1, 0, 16'h0200);
         chk($sformatf("ovf.ret%0d.sel", i), 32'(pc_sel), 32'd3);
         chk($sformatf("ovf.ret%0d.ras", i), 32'(ras_out), 32'h0104 - 32'(i));
         step(0, NOP, 1, 0, 16'h0000);
      end
      step(0, RET, 1, 0, 16'h0200);
      chk_out("ovf.underflow", 2'd0, 1'b1, 1'b0);
      chk("ovf.underflow.err", 32'(stack_err), 32'd1);

      // Reset arriving in the middle of a flush.
      step(1, NOP, 0, 0, 16'h0000);
      step(0, JMP, 1, 0, 16'h0040);
      chk_out("midflush.jmp", 2'd1, 1'b1, 1'b1);
      step(1, JMP, 1, 0, 16'h0041);
      chk_out("midflush.rst", 2'd0, 1'b1, 1'b0);
      step(0, BRZ, 1, 1, 16'h0042);
      chk_out("midflush.run", 2'd2, 1'b1, 1'b1);

      // Redirect counter: three taken redirects after reset.
      step(1, NOP, 0, 0, 16'h0000);
      chk("perf.reset", 32'(redirect_cnt), 32'd0);
      step(0, JMP, 1, 0, 16'h0050);
      step(0, NOP, 1, 0, 16'h0051);
      step(0, BRZ, 1, 1, 16'h0052);
      step(0, NOP, 1, 0, 16'h0053);
      step(0, BRZ, 1, 0, 16'h0054);
      step(0, CALL, 1, 0, 16'h0055);
      step(0, NOP, 1, 0, 16'h0056);
`ifdef PC_SRC_PERF_EN
      chk("perf.count", 32'(redirect_cnt), 32'd3);
`else
      chk("perf.count", 32'(redirect_cnt), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
